// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word at a time over a
// req/ready + rvalid handshake, holds it until retire, then advances the PC.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_src,
  input  logic [1:0]  jump,
  input  logic [31:0] branch_offset,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  input  logic        retire,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misaligned,
  output logic [31:0] retired_cnt
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] cnt_q, cnt_d;
  logic        mis_q, mis_d;
  logic [31:0] next_pc;
  logic        retire_ok;
  logic        next_misaligned;

  assign pc_plus4        = pc_q + 32'd4;
  assign retire_ok       = (state_q == S_HOLD) && retire;
  assign next_misaligned = (next_pc[1:0] != 2'b00);

  // pc_src is only consulted on the sequential/branch path, so an X on it
  // while jumping never reaches the PC.
  always_comb begin
    next_pc = pc_plus4;
    if (jump[1])
      next_pc = jr_target;
    else if (jump[0])
      next_pc = {pc_plus4[31:28], jump_index, 2'b00};
    else if (pc_src)
      next_pc = pc_plus4 + (branch_offset << 2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= S_FETCH;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (imem_ready)  state_d = S_WAIT;
      S_WAIT:  if (imem_rvalid) state_d = S_HOLD;
      S_HOLD:  if (retire)      state_d = next_misaligned ? S_HALT : S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req    = rst_n && (state_q == S_FETCH);
    imem_addr   = pc_q;
    instr_valid = (state_q == S_HOLD);
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    if ((state_q == S_WAIT) && imem_rvalid)
      instr_d = imem_rdata;
    if (retire_ok) begin
      cnt_d = cnt_q + 32'd1;
      if (next_misaligned)
        mis_d = 1'b1;
      else
        pc_d = next_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  assign pc          = pc_q;
  assign instr       = instr_q;
  assign misaligned  = mis_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: next-PC vector table run through a
// zero-wait memory, plus hand sequences for stall, reset-in-WAIT and fault.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_src;
  logic [1:0]  jump;
  logic [31:0] branch_offset;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic        retire;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misaligned;
  logic [31:0] retired_cnt;

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .jump(jump),
    .branch_offset(branch_offset), .jump_index(jump_index),
    .jr_target(jr_target), .retire(retire), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .misaligned(misaligned), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  jump;
    logic        pc_src;
    logic [31:0] boff;
    logic [25:0] jidx;
    logic [31:0] jrt;
    logic [31:0] rdata;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{2'b00, 1'b0, 32'h0000_0000, 26'h0,       32'h0,         32'h1111_0001, 32'h0000_0004};
    vecs[1]  = '{2'b01, 1'b0, 32'h0000_0000, 26'h0000004, 32'h0,         32'h1111_0002, 32'h0000_0010};
    vecs[2]  = '{2'b00, 1'b0, 32'h0000_0007, 26'h0,       32'h0,         32'h1111_0003, 32'h0000_0014};
    vecs[3]  = '{2'b10, 1'b1, 32'h0000_0000, 26'h0,       32'h0000_0020, 32'h1111_0004, 32'h0000_0020};
    vecs[4]  = '{2'b00, 1'b1, 32'hFFFF_FFFE, 26'h0,       32'h0,         32'h1111_0005, 32'h0000_001C};
    vecs[5]  = '{2'b01, 1'bx, 32'hFFFF_FFFE, 26'h0000040, 32'h0,         32'h1111_0006, 32'h0000_0100};
    vecs[6]  = '{2'b00, 1'b1, 32'h0000_0003, 26'h0,       32'h0,         32'h1111_0007, 32'h0000_0110};
    vecs[7]  = '{2'b11, 1'bx, 32'h0000_0000, 26'h0,       32'hFFFF_FFFC, 32'h1111_0008, 32'hFFFF_FFFC};
    vecs[8]  = '{2'b00, 1'b0, 32'h0000_0000, 26'h0,       32'h0,         32'h1111_0009, 32'h0000_0000};
    vecs[9]  = '{2'b01, 1'b0, 32'h0000_0000, 26'h3FFFFFF, 32'h0,         32'h1111_000A, 32'h0FFF_FFFC};
    vecs[10] = '{2'b00, 1'b0, 32'h0000_0100, 26'h0,       32'h0,         32'h1111_000B, 32'h1000_0000};
    vecs[11] = '{2'b01, 1'b0, 32'h0000_0000, 26'h0000001, 32'h0,         32'h1111_000C, 32'h1000_0004};

    rst_n = 1'b0; pc_src = 1'b0; jump = 2'b00; branch_offset = '0;
    jump_index = '0; jr_target = '0; retire = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    tick(); tick();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_mis", {31'b0, misaligned}, 32'd0);
    chk("rst_cnt", retired_cnt, 32'd0);

    // Cycle 1: release with ready high, request accepted.
    rst_n = 1'b1; imem_ready = 1'b1;
    #1;
    chk("c1_req", {31'b0, imem_req}, 32'd1);
    chk("c1_addr", imem_addr, 32'h0);
    tick();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2008_0005;
    chk("c2_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    imem_rvalid = 1'b0;
    chk("c3_valid", {31'b0, instr_valid}, 32'd1);
    chk("c3_instr", instr, 32'h2008_0005);
    chk("c3_pc", pc, 32'h0);

    // Each vector: retire at t, FETCH at t+1, rvalid at t+2, valid at t+3.
    for (int i = 0; i < 12; i++) begin
      retire = 1'b1; jump = vecs[i].jump; pc_src = vecs[i].pc_src;
      branch_offset = vecs[i].boff; jump_index = vecs[i].jidx;
      jr_target = vecs[i].jrt;
      tick();
      retire = 1'b0; pc_src = 1'b0; jump = 2'b00;
      chk($sformatf("v%0d_req", i), {31'b0, imem_req}, 32'd1);
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_pc);
      chk($sformatf("v%0d_cnt", i), retired_cnt, 32'(i + 1));
      chk($sformatf("v%0d_nvalid", i), {31'b0, instr_valid}, 32'd0);
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = vecs[i].rdata;
      tick();
      imem_rvalid = 1'b0;
      chk($sformatf("v%0d_valid", i), {31'b0, instr_valid}, 32'd1);
      chk($sformatf("v%0d_instr", i), instr, vecs[i].rdata);
      chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("v%0d_pc4", i), pc_plus4, vecs[i].exp_pc + 32'd4);
      chk($sformatf("v%0d_mis", i), {31'b0, misaligned}, 32'd0);
    end

    // Stray rvalid in HOLD, then a 5-cycle ready stall with stray rvalid/retire.
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("hold_stray_instr", instr, 32'h1111_000C);
    retire = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("stall_req", {31'b0, imem_req}, 32'd1);
      chk("stall_addr", imem_addr, 32'h1000_0008);
      imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
      retire = 1'b1;
      tick();
    end
    retire = 1'b0; imem_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD1_BAD1;
    chk("stall_cnt", retired_cnt, 32'd13);
    chk("stall_instr", instr, 32'h1111_000C);
    tick();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_rvalid = 1'b0;
    chk("stall_valid", {31'b0, instr_valid}, 32'd1);
    chk("stall_load", instr, 32'h1234_5678);
    chk("stall_pc", pc, 32'h1000_0008);

    // Reset asserted in WAIT; the late response after release must be dropped.
    retire = 1'b1;
    tick();
    retire = 1'b0; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rw_req", {31'b0, imem_req}, 32'd0);
    chk("rw_pc", pc, 32'h0);
    chk("rw_cnt", retired_cnt, 32'd0);
    tick();
    rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_0001;
    #1;
    chk("rw_rel_req", {31'b0, imem_req}, 32'd1);
    chk("rw_rel_addr", imem_addr, 32'h0);
    tick();
    imem_rvalid = 1'b0;
    chk("rw_drop_valid", {31'b0, instr_valid}, 32'd0);
    chk("rw_drop_instr", instr, 32'h0);
    chk("rw_still_req", {31'b0, imem_req}, 32'd1);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_0002;
    tick();
    imem_rvalid = 1'b0;
    chk("rw_valid", {31'b0, instr_valid}, 32'd1);
    chk("rw_instr", instr, 32'hCAFE_0002);

    // Misaligned jr: fault, HALT forever, retire ignored.
    retire = 1'b1; jump = 2'b10; jr_target = 32'h0000_0402;
    tick();
    retire = 1'b0; jump = 2'b00;
    for (int k = 0; k < 20; k++) begin
      chk("halt_req", {31'b0, imem_req}, 32'd0);
      chk("halt_valid", {31'b0, instr_valid}, 32'd0);
      chk("halt_mis", {31'b0, misaligned}, 32'd1);
      retire = (k == 5); imem_ready = 1'b1; imem_rvalid = 1'b1;
      tick();
    end
    retire = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
    chk("halt_cnt", retired_cnt, 32'd1);
    chk("halt_pc", pc, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
